// File: rtl/process_scheduler.sv
// Round-robin process scheduler: picks the next ready PID after a preempt, yield or exit,
// issues a context-switch request and commits running_pid once the switch is acknowledged.
module process_scheduler #(
    parameter int NPROC       = 16,
    parameter int ACK_TIMEOUT = 32,
    localparam int PW         = $clog2(NPROC),
    localparam int TW         = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             preempt_request,
    input  logic             yield_req,
    input  logic             exit_req,
    input  logic             create_valid,
    input  logic [PW-1:0]    create_idx,
    output logic             context_switch_request,
    output logic [7:0]       new_pid,
    input  logic             context_switch_complete,
    output logic [7:0]       running_pid,
    output logic [NPROC-1:0] ready_mask,
    output logic             sched_busy,
    output logic [15:0]      switch_count,
    output logic             ack_timeout_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECT   = 2'd1,
        ST_REQUEST  = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_e;

    state_e           state_q;
    logic [PW-1:0]    run_q;
    logic [PW-1:0]    new_q;
    logic [NPROC-1:0] ready_q;
    logic [NPROC-1:0] ready_d;
    logic             pending_q;
    logic             csr_q;
    logic             err_q;
    logic [15:0]      count_q;
    logic [TW-1:0]    timer_q;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    scan_idx;
    logic             cand_found;
    logic             trigger;

    assign trigger = preempt_request | yield_req | exit_req | pending_q;

    // Exit only retires the running slot while idle; a same-cycle create wins; slot 0 never retires.
    always_comb begin
        ready_d = ready_q;
        if (state_q == ST_IDLE && exit_req && run_q != '0) begin
            ready_d[run_q] = 1'b0;
        end
        if (create_valid) begin
            ready_d[create_idx] = 1'b1;
        end
        ready_d[0] = 1'b1;
    end

    // Scan run+1 .. run+NPROC (mod NPROC); slot 0 is only chosen when nothing else is ready.
    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        scan_idx   = '0;
        for (int i = 1; i <= NPROC; i++) begin
            scan_idx = run_q + PW'(i);
            if (!cand_found && scan_idx != '0 && ready_q[scan_idx]) begin
                cand       = scan_idx;
                cand_found = 1'b1;
            end
        end
    end

    // Handshake: context_switch_request pulses for one cycle with new_pid stable; the switch
    // commits on the first cycle context_switch_complete is high while in WAIT_ACK, and is
    // abandoned (sticky error) if no complete arrives within ACK_TIMEOUT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            run_q     <= '0;
            new_q     <= '0;
            ready_q   <= NPROC'(1);
            pending_q <= 1'b0;
            csr_q     <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
            timer_q   <= '0;
        end else begin
            ready_q <= ready_d;
            case (state_q)
                ST_IDLE: begin
                    csr_q <= 1'b0;
                    if (trigger) begin
                        pending_q <= 1'b0;
                        state_q   <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (preempt_request) pending_q <= 1'b1;
                    if (cand == run_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        new_q   <= cand;
                        csr_q   <= 1'b1;
                        state_q <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (preempt_request) pending_q <= 1'b1;
                    csr_q   <= 1'b0;
                    timer_q <= '0;
                    state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (preempt_request) pending_q <= 1'b1;
                    if (context_switch_complete) begin
                        run_q   <= new_q;
                        count_q <= count_q + 16'd1;
                        state_q <= ST_IDLE;
                    end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign context_switch_request = csr_q;
    assign new_pid                = 8'(new_q);
    assign running_pid            = 8'(run_q);
    assign ready_mask             = ready_q;
    assign sched_busy             = (state_q != ST_IDLE);
    assign switch_count           = count_q;
    assign ack_timeout_err        = err_q;
    assign dbg_state              = state_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: scheduling table, hand-written corner sequences, and
// randomized reschedules checked against a transaction-level ready-set model.
module tb_process_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        preempt_request, yield_req, exit_req, create_valid;
    logic [3:0]  create_idx;
    logic        context_switch_request;
    logic [7:0]  new_pid;
    logic        context_switch_complete;
    logic [7:0]  running_pid;
    logic [15:0] ready_mask;
    logic        sched_busy;
    logic [15:0] switch_count;
    logic        ack_timeout_err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_mask;
    int          m_run;
    int          m_cnt;

    process_scheduler #(.NPROC(16), .ACK_TIMEOUT(32)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .preempt_request         (preempt_request),
        .yield_req               (yield_req),
        .exit_req                (exit_req),
        .create_valid            (create_valid),
        .create_idx              (create_idx),
        .context_switch_request  (context_switch_request),
        .new_pid                 (new_pid),
        .context_switch_complete (context_switch_complete),
        .running_pid             (running_pid),
        .ready_mask              (ready_mask),
        .sched_busy              (sched_busy),
        .switch_count            (switch_count),
        .ack_timeout_err         (ack_timeout_err),
        .dbg_state               (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [15:0] creates;
        logic [2:0]  trig;     // bit0 preempt, bit1 yield, bit2 exit
        bit          exp_req;
        int          exp_pid;
        int          exp_run;
        int          exp_cnt;
        logic [15:0] exp_mask;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_creates(input logic [15:0] m);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                create_valid = 1'b1;
                create_idx   = 4'(i);
                tick();
            end
        end
        create_valid = 1'b0;
    endtask

    task automatic fire(input logic [2:0] t);
        preempt_request = t[0];
        yield_req       = t[1];
        exit_req        = t[2];
        tick();
        preempt_request = 1'b0;
        yield_req       = 1'b0;
        exit_req        = 1'b0;
    endtask

    task automatic wait_req(output bit got, output int lat);
        lat = 0;
        while (!context_switch_request && lat < 6) begin
            tick();
            lat++;
        end
        got = context_switch_request;
    endtask

    // Called one cycle into WAIT_ACK; optionally creates random slots while the ack is held off.
    task automatic finish_ack(input int delay, input bit rnd);
        int idx;
        for (int i = 0; i < delay; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                idx          = $urandom_range(0, 15);
                create_valid = 1'b1;
                create_idx   = 4'(idx);
                m_mask[idx]  = 1'b1;
            end
            tick();
            create_valid = 1'b0;
        end
        context_switch_complete = 1'b1;
        tick();
        context_switch_complete = 1'b0;
    endtask

    function automatic int model_next(input int run, input logic [15:0] mask);
        int p;
        for (int k = 1; k <= 16; k++) begin
            p = (run + k) % 16;
            if (p != 0 && mask[p]) return p;
        end
        return 0;
    endfunction

    initial begin
        bit   got;
        int   lat;
        int   exp;
        int   r;
        logic [2:0]  t;
        logic [15:0] cm;

        vecs[0]  = '{16'h0028, 3'b001, 1'b1,  3,  3, 1, 16'h0029};
        vecs[1]  = '{16'h0000, 3'b010, 1'b1,  5,  5, 2, 16'h0029};
        vecs[2]  = '{16'h0000, 3'b001, 1'b1,  3,  3, 3, 16'h0029};
        vecs[3]  = '{16'h0000, 3'b100, 1'b1,  5,  5, 4, 16'h0021};
        vecs[4]  = '{16'h0000, 3'b001, 1'b0,  0,  5, 4, 16'h0021};
        vecs[5]  = '{16'h0000, 3'b100, 1'b1,  0,  0, 5, 16'h0001};
        vecs[6]  = '{16'h0000, 3'b001, 1'b0,  0,  0, 5, 16'h0001};
        vecs[7]  = '{16'h8002, 3'b010, 1'b1,  1,  1, 6, 16'h8003};
        vecs[8]  = '{16'h0000, 3'b001, 1'b1, 15, 15, 7, 16'h8003};
        vecs[9]  = '{16'h0000, 3'b001, 1'b1,  1,  1, 8, 16'h8003};
        vecs[10] = '{16'h0000, 3'b100, 1'b1, 15, 15, 9, 16'h8001};
        vecs[11] = '{16'h0000, 3'b010, 1'b0,  0, 15, 9, 16'h8001};

        rst_n = 1'b0;
        preempt_request = 1'b0; yield_req = 1'b0; exit_req = 1'b0;
        create_valid = 1'b0; create_idx = '0; context_switch_complete = 1'b0;
        tick(); tick();
        chk("rst_ready_mask", 32'(ready_mask), 1);
        chk("rst_running_pid", 32'(running_pid), 0);
        chk("rst_new_pid", 32'(new_pid), 0);
        chk("rst_request", 32'(context_switch_request), 0);
        chk("rst_busy", 32'(sched_busy), 0);
        chk("rst_count", 32'(switch_count), 0);
        chk("rst_err", 32'(ack_timeout_err), 0);
        rst_n = 1'b1;
        tick();

        // Scheduling table
        for (int v = 0; v < 12; v++) begin
            apply_creates(vecs[v].creates);
            fire(vecs[v].trig);
            chk($sformatf("tbl%0d_busy_select", v), 32'(sched_busy), 1);
            wait_req(got, lat);
            chk($sformatf("tbl%0d_req", v), 32'(got), 32'(vecs[v].exp_req));
            if (got) begin
                chk($sformatf("tbl%0d_latency", v), lat, 1);
                chk($sformatf("tbl%0d_new_pid", v), 32'(new_pid), vecs[v].exp_pid);
                tick();
                chk($sformatf("tbl%0d_req_one_cycle", v), 32'(context_switch_request), 0);
                finish_ack($urandom_range(0, 5), 1'b0);
            end
            chk($sformatf("tbl%0d_running", v), 32'(running_pid), vecs[v].exp_run);
            chk($sformatf("tbl%0d_count", v), 32'(switch_count), vecs[v].exp_cnt);
            chk($sformatf("tbl%0d_mask", v), 32'(ready_mask), 32'(vecs[v].exp_mask));
            chk($sformatf("tbl%0d_busy_done", v), 32'(sched_busy), 0);
        end

        // Preempt during WAIT_ACK leaves a pending reschedule
        apply_creates(16'h0010);
        fire(3'b001);
        wait_req(got, lat);
        chk("pend_first_req", 32'(got), 1);
        chk("pend_first_pid", 32'(new_pid), 4);
        tick();
        preempt_request = 1'b1;
        tick();
        preempt_request = 1'b0;
        context_switch_complete = 1'b1;
        tick();
        context_switch_complete = 1'b0;
        chk("pend_commit_run", 32'(running_pid), 4);
        chk("pend_commit_cnt", 32'(switch_count), 10);
        wait_req(got, lat);
        chk("pend_second_req", 32'(got), 1);
        chk("pend_second_lat", lat, 2);
        chk("pend_second_pid", 32'(new_pid), 15);
        tick();
        finish_ack(0, 1'b0);
        chk("pend_second_run", 32'(running_pid), 15);
        chk("pend_second_cnt", 32'(switch_count), 11);
        repeat (4) tick();
        chk("pend_consumed", 32'(sched_busy), 0);

        // Simultaneous triggers collapse into one reschedule
        fire(3'b011);
        wait_req(got, lat);
        chk("multi_req", 32'(got), 1);
        chk("multi_pid", 32'(new_pid), 4);
        tick();
        finish_ack(2, 1'b0);
        repeat (3) tick();
        chk("multi_single", 32'(sched_busy), 0);
        chk("multi_cnt", 32'(switch_count), 12);

        // Create and exit on the running slot in the same cycle: create wins
        create_valid = 1'b1; create_idx = 4'd4; exit_req = 1'b1;
        tick();
        create_valid = 1'b0; exit_req = 1'b0;
        wait_req(got, lat);
        chk("cx_req", 32'(got), 1);
        chk("cx_pid", 32'(new_pid), 15);
        chk("cx_mask", 32'(ready_mask), 32'h8011);
        tick();
        finish_ack(1, 1'b0);
        chk("cx_run", 32'(running_pid), 15);
        apply_creates(16'h8000);
        chk("create_noop_mask", 32'(ready_mask), 32'h8011);

        // Ack withheld until timeout
        fire(3'b001);
        wait_req(got, lat);
        chk("to_req", 32'(got), 1);
        chk("to_pid", 32'(new_pid), 4);
        tick();
        repeat (31) tick();
        chk("to_err_early", 32'(ack_timeout_err), 0);
        chk("to_busy_early", 32'(sched_busy), 1);
        tick();
        chk("to_err_set", 32'(ack_timeout_err), 1);
        chk("to_busy_done", 32'(sched_busy), 0);
        chk("to_run_kept", 32'(running_pid), 15);
        chk("to_cnt_kept", 32'(switch_count), 13);
        context_switch_complete = 1'b1;
        tick();
        context_switch_complete = 1'b0;
        chk("idle_ack_run", 32'(running_pid), 15);
        chk("idle_ack_cnt", 32'(switch_count), 13);
        chk("to_err_sticky", 32'(ack_timeout_err), 1);

        // Reset in the middle of WAIT_ACK
        fire(3'b001);
        wait_req(got, lat);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mask", 32'(ready_mask), 1);
        chk("mid_rst_run", 32'(running_pid), 0);
        chk("mid_rst_new_pid", 32'(new_pid), 0);
        chk("mid_rst_busy", 32'(sched_busy), 0);
        chk("mid_rst_cnt", 32'(switch_count), 0);
        chk("mid_rst_err", 32'(ack_timeout_err), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_req", 32'(context_switch_request), 0);

        // Only PID 0 ready: busy for exactly one cycle, no request
        fire(3'b001);
        chk("self_busy_on", 32'(sched_busy), 1);
        tick();
        chk("self_busy_off", 32'(sched_busy), 0);
        chk("self_no_req", 32'(context_switch_request), 0);

        // Randomized reschedules against the ready-set model
        m_mask = 16'h0001; m_run = 0; m_cnt = 0;
        for (int it = 0; it < 150; it++) begin
            cm = '0;
            repeat ($urandom_range(0, 2)) cm[$urandom_range(0, 15)] = 1'b1;
            apply_creates(cm);
            m_mask = m_mask | cm;
            r = $urandom_range(0, 9);
            if (r < 4)       t = 3'b001;
            else if (r < 7)  t = 3'b010;
            else if (r < 9)  t = 3'b100;
            else             t = 3'b011;
            if (t[2] && m_run != 0) m_mask[m_run] = 1'b0;
            exp = model_next(m_run, m_mask);
            fire(t);
            wait_req(got, lat);
            chk($sformatf("rnd%0d_req", it), 32'(got), 32'(exp != m_run));
            if (got) begin
                chk($sformatf("rnd%0d_pid", it), 32'(new_pid), exp);
                tick();
                finish_ack($urandom_range(0, 20), 1'b1);
                m_run = exp;
                m_cnt++;
            end
            chk($sformatf("rnd%0d_run", it), 32'(running_pid), m_run);
            chk($sformatf("rnd%0d_cnt", it), 32'(switch_count), m_cnt);
            chk($sformatf("rnd%0d_mask", it), 32'(ready_mask), 32'(m_mask));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
